// File: rtl/imem_fb_pkg.sv
// Shared types and constants for the instruction-fetch prefetch buffer.
package imem_fb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = XLEN / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fb_state_t;

    // One prefetched word together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fb_entry_t;

endpackage

// File: rtl/imem_fb_fifo.sv
// Circular buffer of address-tagged fetch entries; flush beats push and pop.
module imem_fb_fifo
    import imem_fb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fb_entry_t              wdata_i,
    output fb_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fb_entry_t         mem_q [DEPTH];
    fb_entry_t         mem_d [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PtrW + 1)'(1);
                2'b01:   count_d = count_q - (PtrW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/imem_fetch_buffer.sv
// Instruction-fetch prefetch buffer: serves sequential fetches from an address-tagged
// FIFO in zero cycles and restarts the memory stream on a redirect.
// Optional hit/miss counters are enabled by defining IMEM_FB_PERF_EN.
// XLEN must match imem_fb_pkg::XLEN, which sizes the stored entries.
module imem_fetch_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    input  logic [XLEN-1:0] core_addr,
    output logic [XLEN-1:0] core_rdata,
    output logic            core_ready,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready
`ifdef IMEM_FB_PERF_EN
    ,
    output logic [31:0]     hit_cnt,
    output logic [31:0]     miss_cnt
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    imem_fb_pkg::fb_state_t state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic [XLEN-1:0]        mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]        nxt_addr_q, nxt_addr_d;
    logic                   drop_q, drop_d;

    imem_fb_pkg::fb_entry_t head, push_entry;
    logic [CntW-1:0]        fifo_count;
    logic [CntW:0]          fill;
    logic                   fifo_full, fifo_empty, fifo_push;
    logic                   hit, miss, redirect_pending, pending_fill;

    // A live outstanding access will land in the buffer; a dropped one will not.
    assign pending_fill = (state_q == imem_fb_pkg::WAIT) && !drop_q;
    assign fill         = {1'b0, fifo_count} + (CntW + 1)'(pending_fill);

    assign hit = core_req && !fifo_empty && (head.addr == core_addr);

    // Empty buffer, but the stream is already heading to core_addr: just wait for it.
    assign redirect_pending = fifo_empty &&
        ((pending_fill && (mem_addr_q == core_addr)) ||
         (((state_q == imem_fb_pkg::IDLE) || drop_q) && (nxt_addr_q == core_addr)));

    assign miss = core_req && !hit && !redirect_pending;

    // A redirect in the same cycle as a response discards that response.
    assign fifo_push       = (state_q == imem_fb_pkg::WAIT) && mem_ready && !drop_q && !miss;
    assign push_entry.addr = mem_addr_q;
    assign push_entry.data = mem_rdata;

    imem_fb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .pop_i   (hit),
        .flush_i (miss),
        .wdata_i (push_entry),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign core_ready = hit;
    assign core_rdata = hit ? head.data : '0;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    // Memory-side FSM: issue the next sequential word, retire it, track drops.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        nxt_addr_d = nxt_addr_q;
        drop_d     = drop_q;
        case (state_q)
            imem_fb_pkg::IDLE: begin
                if (miss) begin
                    // Buffer is flushed, so go straight to the redirect target.
                    nxt_addr_d = core_addr;
                    state_d    = imem_fb_pkg::WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = core_addr;
                end else if (!fifo_full && (fill < (CntW + 1)'(DEPTH)) && !drop_q) begin
                    state_d    = imem_fb_pkg::WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = nxt_addr_q;
                end
            end
            imem_fb_pkg::WAIT: begin
                if (mem_ready) begin
                    state_d   = imem_fb_pkg::IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (miss) begin
                        nxt_addr_d = core_addr;
                    end else if (!drop_q) begin
                        nxt_addr_d = mem_addr_q + XLEN'(imem_fb_pkg::WORD_BYTES);
                    end
                end else if (miss) begin
                    drop_d     = 1'b1;
                    nxt_addr_d = core_addr;
                end
            end
            default: state_d = imem_fb_pkg::IDLE;
        endcase
    end

    // FSM and fetch-pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= imem_fb_pkg::IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            nxt_addr_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            nxt_addr_q <= nxt_addr_d;
            drop_q     <= drop_d;
        end
    end

`ifdef IMEM_FB_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        awaiting_q, awaiting_d;

    // Count each access once: a miss is counted at its redirect, so its eventual
    // delivery is not counted again as a hit.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        awaiting_d = awaiting_q;
        if (miss) begin
            awaiting_d = 1'b1;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
        end else if (hit) begin
            if (awaiting_q) begin
                awaiting_d = 1'b0;
            end else if (hit_cnt_q != '1) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    // Saturating performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            awaiting_q <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            awaiting_q <= awaiting_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/imem_fetch_buffer.md
# imem_fetch_buffer

Parametrised instruction-fetch prefetch buffer between the core fetch stage and instruction memory. It speaks the existing req/addr/rdata/ready handshake on both sides. Sequential words are prefetched into a DEPTH-entry address-tagged FIFO, so straight-line fetches complete in zero cycles. A redirect (address mismatch) flushes the buffer and restarts fetching at the new address.

## Interface
- XLEN, 32: address/data width; address stride is XLEN/8.
- DEPTH, 4: prefetch entries; power of two, ≥2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- core_req  input  1  core fetch request; held with core_addr until core_ready.
- core_addr  input  XLEN  fetch address.
- core_rdata  output  XLEN  instruction word; valid when core_ready, else 0.
- core_ready  output  1  request completed this cycle.
- mem_req  output  1  memory request; held with mem_addr until mem_ready.
- mem_addr  output  XLEN  memory address.
- mem_rdata  input  XLEN  memory data; valid when mem_ready.
- mem_ready  input  1  memory request completed this cycle.
- hit_cnt  output  32  core hits (only with IMEM_FB_PERF_EN).
- miss_cnt  output  32  core misses (only with IMEM_FB_PERF_EN).

## Operation
- Entry = {addr, data}. Count 0..DEPTH. Registers: fetch pointer `nxt_addr`; memory FSM {IDLE, WAIT}; `drop` flag.
- Hit: core_req && !empty && head.addr == core_addr.
  - core_ready=1 and core_rdata=head.data combinationally, same cycle.
  - Head pops at the clock edge.
- Miss: core_req && (empty || head.addr != core_addr) && !redirect_pending.
  - Flush all entries.
  - nxt_addr ← core_addr.
  - If FSM is WAIT, set drop.
- Core request arriving at an empty buffer whose pending fetch already targets core_addr is not a miss. The core waits.
- Memory FSM:
  - IDLE→WAIT when (count + pending_fill) < DEPTH and no unresolved drop. Register mem_req=1 and mem_addr=nxt_addr.
  - In WAIT, on mem_ready:
    - If drop: discard mem_rdata and clear drop.
    - Otherwise: push {mem_addr, mem_rdata}.
    - In both cases nxt_addr ← mem_addr + XLEN/8 (the flushed path instead uses the redirect address), then WAIT→IDLE.
  - mem_req/mem_addr never change while WAIT and mem_ready=0.
- Address arithmetic is modulo 2^XLEN; 0xFFFF_FFFC + 4 → 0x0000_0000.
- Comparisons use the full address. A misaligned core_addr is fetched as given.
- Full: no new mem_req is issued while count == DEPTH.
- Simultaneous pop and push in the same cycle: count is unchanged.
- Simultaneous miss and mem_ready with drop=0 and a mismatching address: flush wins and the returning word is discarded.
- Reset mid-transaction: all state clears. The first response after reset, if the memory still returns one, is ignored because mem_req was deasserted. The memory side must tolerate request withdrawal on rst only.

## Timing
- Reset values:
  - core_ready=0, core_rdata=0.
  - mem_req=0, mem_addr=0.
  - Count 0, FSM IDLE, drop=0, nxt_addr=0.
  - hit_cnt=0, miss_cnt=0.
- Hit latency: 0 cycles.
- Miss latency:
  - Miss at cycle N → mem_req at N+1.
  - mem_ready at M → entry visible and core_ready at M+1.
  - Minimum 2 cycles with a single-cycle memory.
- Redirect during WAIT: adds the remaining latency of the outstanding access, plus one IDLE cycle.
- Sustained throughput with a 1-cycle memory: one word per 2 cycles from the memory side. The buffer absorbs core stalls.

## Configuration
- IMEM_FB_PERF_EN defined:
  - Ports hit_cnt/miss_cnt exist.
  - Each is incremented once per completed core access: a hit counts in the core_ready cycle; a miss counts in its redirect cycle.
  - Both saturate at 2^32−1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package imem_fb_pkg holds:
  - the `fb_state_t` enum {IDLE, WAIT};
  - the `fb_entry_t` struct {addr, data}, parametrised via XLEN from the package default;
  - localparam WORD_BYTES = XLEN/8.
- Sub-module imem_fb_fifo: circular buffer of fb_entry_t with push/pop/flush, head output, count, full/empty. Flush has priority over push.

## Test plan
- Reset, then core_req addr 0x0 with memory ready 1 cycle after req:
  - mem_addr 0x0, then 0x4, 0x8, 0xC.
  - core_ready for 0x0 two cycles after core_req.
  - Fetch stops at 4 entries.
- Prefill 4 entries from 0x100, core fetches 0x100..0x10C back-to-back → four consecutive 0-latency hits with correct data.
- Fetching 0x100, then a jump to 0x200 while a fetch of 0x104 is in WAIT:
  - the 0x104 data is dropped;
  - the next mem_addr is 0x200;
  - core receives the 0x200 data.
- Start at 0xFFFF_FFF8 → mem_addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Memory holds mem_ready low for 5 cycles → mem_req and mem_addr stay stable; rst asserted in cycle 3 → mem_req=0 and count=0 the next cycle.
- IMEM_FB_PERF_EN defined: 3 hits, 1 miss → hit_cnt=3, miss_cnt=1.
